encoder_bank: RTL
=================

Name: encoder_bank

Overview:
Multi-channel rotary encoder interface with a register bus. Per channel, the block:
- synchronises and debounces the A/B pins
- decodes quadrature movement
- accumulates a WIDTH-bit value inside programmable [min,max] bounds, with saturate or wrap mode and optional velocity acceleration
- raises a sticky change flag for the CPU

It sits on the peripheral bus in place of discrete single-encoder instances.

Parameters:
CHANNELS, 4, number of encoder channels (1..16)
WIDTH, 16, value/min/max/bus data width
DEBOUNCE_WIDTH, 11, debounce counter width; input must be stable 2^DEBOUNCE_WIDTH cycles
TIMER_WIDTH, 20, velocity sampling window is 2^TIMER_WIDTH cycles
VELOCITY_SHIFT, 3, step = (pulses in previous window << VELOCITY_SHIFT) + 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
a  in  CHANNELS  encoder A pins, bit i = channel i
b  in  CHANNELS  encoder B pins
addr  in  clog2(CHANNELS)+2  {channel, reg}; reg 0=value, 1=min, 2=max, 3=ctrl
we  in  1  write strobe, single cycle
din  in  WIDTH  write data
q  out  WIDTH  read data, combinational from addr
irq  out  1  OR of all channel pending flags, registered

Behaviour:
- Reset: every value=0, min=0, max=all-ones, ctrl.wrap=0, ctrl.accel=1, pending=0, step=1, pulse counters=0, timer=0, irq=0. Debouncer outputs reset to 0.
- ctrl layout: bit0 wrap, bit1 accel, bit WIDTH-1 pending; other bits read 0.
- Writing ctrl with bit WIDTH-1=1 clears pending (write-1-to-clear). Writing 0 to that bit leaves pending unchanged.
- Debounce, per pin: a counter increments while input != output and resets to 0 when they are equal. When the counter saturates at all-ones, output takes the input value on the next cycle.
- Decoder, per channel: registers the previous debounced a/b.
  - cnt = a^a_prev^b^b_prev; dir = a^b_prev (1 = up). This gives 4 counts per detent.
  - Both pins changing in one cycle gives cnt=0, so the movement is ignored.
- Velocity: one shared timer, TIMER_WIDTH bits, free-running, wraps.
  - Each channel has a saturating WIDTH-bit pulse counter, incremented on cnt.
  - On timer all-ones: pulse counter clears, and step = accel ? min(all-ones, (pulses<<VELOCITY_SHIFT)+1) : 1.
  - Shift is computed in WIDTH+VELOCITY_SHIFT bits, then saturated.
  - accel=0 forces step=1 from the next cycle.
- Value update, registered, 1 cycle after cnt. All arithmetic is in WIDTH+1 bits.
  - Up: if value+step > max, result = wrap ? min : max; else value+step.
  - Down: if value < min+step, result = wrap ? max : min; else value-step.
  - If min > max, movement is ignored and value holds.
  - If the result differs from the old value, pending is set.
- Bus writes land on the next clock edge. A write to value stores din unclamped; later movement applies the bounds from the stored value.
- Simultaneous write and movement on the same channel: the write wins and the step is discarded. Pending is still set if cnt occurred.
- Simultaneous W1C and a new change: set wins, so pending stays 1.
- Writes to one channel never affect another channel's state.
- irq is registered: it follows the OR of pending with 1-cycle latency.
- Latency from a pin edge (stable) to value update: sync (see option) + 2^DEBOUNCE_WIDTH + 1 debounce-output cycles, +1 decode/value register.
- Reset asserted mid-debounce or mid-window: all counters clear and no step is applied.

Optional Feature:
ENCODER_BANK_SYNC_EN
- Defined: a and b each pass through 2-flop synchronisers (reset 0) before the debouncer, adding 2 cycles of latency. Used for asynchronous pins.
- Undefined: the pins feed the debouncer directly. Used when the pins are already synchronised upstream.
- No other behaviour differs.

Test Plan:
- Reset, then read every register of ch0..3 -> value=0x0000, min=0x0000, max=0xFFFF, ctrl=0x0002, irq=0.
- DEBOUNCE_WIDTH=2, accel=0: one clockwise detent on ch1 (a leads b, 4 transitions) -> ch1 value=4, pending=1, irq=1 one cycle after pending. Other channels stay 0.
- Saturate and wrap on ch0: min=10, max=20, value=19, two up counts -> value 20, 20. Then set wrap=1 and give one more up count -> value 10. One down count from 10 -> 20.
- Acceleration with TIMER_WIDTH=6: 3 counts in one window -> next step=25. From value 100, one down count -> 75. With max=110, one up count from 100 -> saturates at 110.
- Priority: a value write of 0x1234 in the same cycle as an up count -> value=0x1234, pending=1. W1C in the same cycle as a new count -> pending stays 1. A later W1C alone -> pending=0 and irq=0 one cycle after.
- Glitch and illegal input: a toggles for fewer than 2^DEBOUNCE_WIDTH cycles -> no change. Simultaneous a and b edges -> no change. Setting min=30, max=20 and then moving the encoder -> value holds.

Source files
------------

// File: rtl/encoder_bank_if.sv
// encoder_bank_if: register bus between a CPU-side master and encoder_bank.
// Ports: addr/we/din driven by master, q (combinational read data) by slave.
interface encoder_bank_if #(
  parameter int AW    = 4,
  parameter int WIDTH = 16
);
  logic [AW-1:0]    addr;
  logic             we;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;

  modport master (output addr, we, din, input q);
  modport slave  (input addr, we, din, output q);
endinterface

// File: rtl/encoder_bank.sv
// encoder_bank: multi-channel quadrature encoder bank with register bus.
// Ports: clk, rst_n (sync, active-low), a/b pins, bus (slave), irq.
// Option: ENCODER_BANK_SYNC_EN adds 2-flop synchronisers on a/b.
module encoder_bank #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int DEBOUNCE_WIDTH = 11,
  parameter int TIMER_WIDTH    = 20,
  parameter int VELOCITY_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  encoder_bank_if.slave       bus,
  output logic                irq
);
  localparam int SW = WIDTH + VELOCITY_SHIFT + 1;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [CHANNELS-1:0] a_s, b_s;

`ifdef ENCODER_BANK_SYNC_EN
  logic [CHANNELS-1:0] a_m, b_m;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_m <= '0;
      b_m <= '0;
      a_s <= '0;
      b_s <= '0;
    end else begin
      a_m <= a;
      b_m <= b;
      a_s <= a_m;
      b_s <= b_m;
    end
  end
`else
  assign a_s = a;
  assign b_s = b;
`endif

  logic [2*CHANNELS-1:0]     pin, db;
  logic [DEBOUNCE_WIDTH-1:0] db_cnt [2*CHANNELS];

  assign pin = {b_s, a_s};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2*CHANNELS; i++) begin
      if (!rst_n) begin
        db_cnt[i] <= '0;
        db[i]     <= 1'b0;
      end else if (pin[i] == db[i]) begin
        db_cnt[i] <= '0;
      end else if (&db_cnt[i]) begin
        db[i] <= pin[i];
      end else begin
        db_cnt[i] <= db_cnt[i] + DEBOUNCE_WIDTH'(1);
      end
    end
  end

  logic [CHANNELS-1:0] da, dbb, a_p, b_p;
  logic [CHANNELS-1:0] cnt, dir;

  assign da  = db[CHANNELS-1:0];
  assign dbb = db[2*CHANNELS-1:CHANNELS];
  // a single-pin change is one count; a double change cancels out
  assign cnt = da ^ a_p ^ dbb ^ b_p;
  assign dir = da ^ b_p;

  logic [TIMER_WIDTH-1:0] timer;
  logic                   tick;

  assign tick = &timer;

  logic [3:0] ch_sel;
  logic [1:0] reg_sel;

  assign ch_sel  = 4'(bus.addr >> 2);
  assign reg_sel = bus.addr[1:0];

  logic [WIDTH-1:0] value  [CHANNELS];
  logic [WIDTH-1:0] vmin   [CHANNELS];
  logic [WIDTH-1:0] vmax   [CHANNELS];
  logic [WIDTH-1:0] pulses [CHANNELS];
  logic [WIDTH-1:0] step   [CHANNELS];
  logic [WIDTH-1:0] nxt    [CHANNELS];
  logic [CHANNELS-1:0] wrap, accel, pend;
  logic [CHANNELS-1:0] wr_en, wr_val, wr_ctl, w1c, set;

  function automatic logic [WIDTH-1:0] accel_step(
    input logic [WIDTH-1:0] p
  );
    logic [SW-1:0] s;
    s = (SW'(p) << VELOCITY_SHIFT) + SW'(1);
    accel_step = (s > SW'(ONES)) ? ONES : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] bound_step(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] st,
    input logic             up,
    input logic             wr
  );
    logic [WIDTH:0] sum, floor;
    sum   = {1'b0, v} + {1'b0, st};
    floor = {1'b0, lo} + {1'b0, st};
    bound_step = v;
    if (lo > hi)
      bound_step = v;
    else if (up)
      bound_step = (sum > {1'b0, hi}) ? (wr ? lo : hi)
                                      : sum[WIDTH-1:0];
    else
      bound_step = ({1'b0, v} < floor) ? (wr ? hi : lo)
                                       : v - st;
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_en[i]  = bus.we && (ch_sel == 4'(i));
      wr_val[i] = wr_en[i] && (reg_sel == 2'd0);
      wr_ctl[i] = wr_en[i] && (reg_sel == 2'd3);
      w1c[i]    = wr_ctl[i] && bus.din[WIDTH-1];
      // accel off takes effect at once, not at the window edge
      nxt[i]    = bound_step(value[i], vmin[i], vmax[i],
                             accel[i] ? step[i] : WIDTH'(1),
                             dir[i], wrap[i]);
      // a bus write swallows the step but still flags the movement
      set[i]    = cnt[i] && (wr_val[i] || (nxt[i] != value[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
      irq   <= 1'b0;
      a_p   <= '0;
      b_p   <= '0;
      wrap  <= '0;
      accel <= '1;
      pend  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        value[i]  <= '0;
        vmin[i]   <= '0;
        vmax[i]   <= '1;
        pulses[i] <= '0;
        step[i]   <= WIDTH'(1);
      end
    end else begin
      timer <= timer + TIMER_WIDTH'(1);
      irq   <= |pend;
      a_p   <= da;
      b_p   <= dbb;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_val[i])
          value[i] <= bus.din;
        else if (cnt[i])
          value[i] <= nxt[i];
        if (wr_en[i] && (reg_sel == 2'd1))
          vmin[i] <= bus.din;
        if (wr_en[i] && (reg_sel == 2'd2))
          vmax[i] <= bus.din;
        if (wr_ctl[i]) begin
          wrap[i]  <= bus.din[0];
          accel[i] <= bus.din[1];
        end
        if (set[i])
          pend[i] <= 1'b1;
        else if (w1c[i])
          pend[i] <= 1'b0;
        if (tick) begin
          pulses[i] <= '0;
          step[i]   <= accel[i] ? accel_step(pulses[i])
                                : WIDTH'(1);
        end else begin
          if (cnt[i] && !(&pulses[i]))
            pulses[i] <= pulses[i] + WIDTH'(1);
          if (!accel[i])
            step[i] <= WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    bus.q = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == 4'(i)) begin
        unique case (reg_sel)
          2'd0:    bus.q = value[i];
          2'd1:    bus.q = vmin[i];
          2'd2:    bus.q = vmax[i];
          default: bus.q = {pend[i], {(WIDTH-3){1'b0}},
                            accel[i], wrap[i]};
        endcase
      end
    end
  end
endmodule
